// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the per-sample layer sequencer.
package nn_seq_pkg;

    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int DEFAULT_CW      = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLK_LSB,
        RST_CONV,
        WAIT_CONV,
        CLK_AC,
        OUTPUT
    } seq_state_e;

    // Width of the single layer index register; never narrower than one bit.
    function automatic int layer_idx_width(input int n_layers);
        return (n_layers < 2) ? 1 : $clog2(n_layers);
    endfunction

endpackage

// File: rtl/sample_edge_sync.sv
// Brings the codec sample clock into the clk domain and emits a one-cycle
// start pulse for each synchronised rising edge. The detector only arms once
// a synchronised low has been seen after reset, so a sample_clk that is
// already high when reset releases does not count as an edge.
module sample_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sample_clk,
    output logic start
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic fill1_q, fill1_d;
    logic fill2_q, fill2_d;
    logic armed_q, armed_d;
    logic start_q, start_d;

    // Shift the sample through the chain, track chain fill, arm on a real low and detect 0->1
    always_comb begin
        sync1_d = sample_clk;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill1_d = 1'b1;
        fill2_d = fill1_q;
        armed_d = armed_q | (fill2_q & ~sync2_q);
        start_d = armed_q & sync2_q & ~prev_q;
    end

    // Synchroniser, edge register and arming flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill1_q <= 1'b0;
            fill2_q <= 1'b0;
            armed_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill1_q <= fill1_d;
            fill2_q <= fill2_d;
            armed_q <= armed_d;
            start_q <= start_d;
        end
    end

    assign start = start_q;

endmodule

// File: rtl/layer_sequencer.sv
// Per-sample forward-pass sequencer for the cached dilated causal conv network.
// Walks the conv layers in order with one shared layer index, emits registered
// one-cycle control pulses, and monitors overruns, conv timeouts and pass latency.
module layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int CW       = DEFAULT_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic [N_LAYERS-1:0] conv_out_v,
    input  logic                clear,
    output logic                lsb_clk,
    output logic [N_LAYERS-1:0] conv_rst,
    output logic [N_LAYERS-2:0] ac_clk,
    output logic                out_latch,
    output logic                busy,
    output logic                overrun,
    output logic                fault,
    output logic [CW-1:0]       last_pass_cycles,
    output logic [CW-1:0]       max_pass_cycles
);

    localparam int            LW         = layer_idx_width(N_LAYERS);
    localparam logic [LW-1:0] LAST_LAYER = LW'(N_LAYERS - 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic [CW-1:0]       pass_q, pass_d;
    logic [CW-1:0]       last_q, last_d;
    logic [CW-1:0]       max_q, max_d;
    logic                overrun_q, overrun_d;
    logic                fault_q, fault_d;
    logic                lsb_clk_q, lsb_clk_d;
    logic                out_latch_q, out_latch_d;
    logic                busy_q, busy_d;
    logic [N_LAYERS-1:0] conv_rst_q, conv_rst_d;
    logic [N_LAYERS-2:0] ac_clk_q, ac_clk_d;
    logic                start;
    logic                out_v_sel;
    logic [CW-1:0]       pass_total;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    sample_edge_sync u_sample_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .sample_clk (sample_clk),
        .start      (start)
    );

    // Next state, counters, sticky flags and pulse decode from the next state
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        wait_d     = wait_q;
        pass_d     = pass_q;
        last_d     = last_q;
        max_d      = max_q;
        overrun_d  = overrun_q;
        fault_d    = fault_q;
        out_v_sel  = |(conv_out_v & (N_LAYERS'(1) << layer_q));
        pass_total = sat_inc(pass_q);

        if (clear) begin
            overrun_d = 1'b0;
            fault_d   = 1'b0;
            max_d     = '0;
        end

        if (start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLK_LSB;
                end
            end
            CLK_LSB: begin
                state_d = RST_CONV;
                layer_d = '0;
            end
            RST_CONV: begin
                state_d = WAIT_CONV;
                wait_d  = '0;
            end
            WAIT_CONV: begin
                wait_d = sat_inc(wait_q);
                if (out_v_sel) begin
                    state_d = (layer_q == LAST_LAYER) ? OUTPUT : CLK_AC;
                end else if (wait_q >= WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end
            end
            CLK_AC: begin
                state_d = RST_CONV;
                layer_d = layer_q + 1'b1;
            end
            OUTPUT: begin
                state_d = IDLE;
                last_d  = pass_total;
                max_d   = (pass_total > max_q) ? pass_total : max_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == CLK_LSB) begin
            pass_d = '0;
        end else if (state_q != IDLE) begin
            pass_d = pass_total;
        end

        lsb_clk_d   = (state_d == CLK_LSB);
        out_latch_d = (state_d == OUTPUT);
        busy_d      = (state_d != IDLE);
        conv_rst_d  = (state_d == RST_CONV) ? (N_LAYERS'(1) << layer_d) : '0;
        ac_clk_d    = (state_d == CLK_AC) ? ((N_LAYERS - 1)'(1) << layer_d) : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            wait_q      <= '0;
            pass_q      <= '0;
            last_q      <= '0;
            max_q       <= '0;
            overrun_q   <= 1'b0;
            fault_q     <= 1'b0;
            lsb_clk_q   <= 1'b0;
            out_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            conv_rst_q  <= '0;
            ac_clk_q    <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            wait_q      <= wait_d;
            pass_q      <= pass_d;
            last_q      <= last_d;
            max_q       <= max_d;
            overrun_q   <= overrun_d;
            fault_q     <= fault_d;
            lsb_clk_q   <= lsb_clk_d;
            out_latch_q <= out_latch_d;
            busy_q      <= busy_d;
            conv_rst_q  <= conv_rst_d;
            ac_clk_q    <= ac_clk_d;
        end
    end

    assign lsb_clk          = lsb_clk_q;
    assign conv_rst         = conv_rst_q;
    assign ac_clk           = ac_clk_q;
    assign out_latch        = out_latch_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign fault            = fault_q;
    assign last_pass_cycles = last_q;
    assign max_pass_cycles  = max_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer. A second instance with a
// short TIMEOUT shares all inputs and is only examined in the timeout scenario.
module tb_layer_sequencer;

    localparam int NL  = 3;
    localparam int CWB = 32;

    logic            clk;
    logic            rst;
    logic            sample_clk;
    logic            clear;
    logic [NL-1:0]   conv_out_v;

    logic            lsb_clk;
    logic [NL-1:0]   conv_rst;
    logic [NL-2:0]   ac_clk;
    logic            out_latch;
    logic            busy;
    logic            overrun;
    logic            fault;
    logic [CWB-1:0]  last_pass_cycles;
    logic [CWB-1:0]  max_pass_cycles;

    logic            to_lsb_clk;
    logic [NL-1:0]   to_conv_rst;
    logic [NL-2:0]   to_ac_clk;
    logic            to_out_latch;
    logic            to_busy;
    logic            to_overrun;
    logic            to_fault;
    logic [CWB-1:0]  to_last_pass_cycles;
    logic [CWB-1:0]  to_max_pass_cycles;

    int              assertions_evaluated = 0;
    int              failures             = 0;
    int              multi_hot            = 0;
    int              wait_cfg [NL];
    int              resp_cnt [NL];
    logic [NL-1:0]   spur;
    int              trace [$];

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(32), .CW(CWB)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_clk       (sample_clk),
        .conv_out_v       (conv_out_v),
        .clear            (clear),
        .lsb_clk          (lsb_clk),
        .conv_rst         (conv_rst),
        .ac_clk           (ac_clk),
        .out_latch        (out_latch),
        .busy             (busy),
        .overrun          (overrun),
        .fault            (fault),
        .last_pass_cycles (last_pass_cycles),
        .max_pass_cycles  (max_pass_cycles)
    );

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(16), .CW(CWB)) dut_to (
        .clk              (clk),
        .rst              (rst),
        .sample_clk       (sample_clk),
        .conv_out_v       (conv_out_v),
        .clear            (clear),
        .lsb_clk          (to_lsb_clk),
        .conv_rst         (to_conv_rst),
        .ac_clk           (to_ac_clk),
        .out_latch        (to_out_latch),
        .busy             (to_busy),
        .overrun          (to_overrun),
        .fault            (to_fault),
        .last_pass_cycles (to_last_pass_cycles),
        .max_pass_cycles  (to_max_pass_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conv stand-in: raises out_v[k] in the wait_cfg[k]-th cycle after conv_rst[k]
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (rst) resp_cnt[k] = 0;
            else if (conv_rst[k]) resp_cnt[k] = wait_cfg[k] + 1;
            else if (resp_cnt[k] > 0) resp_cnt[k] = resp_cnt[k] - 1;
        end
    end

    always_comb begin
        for (int k = 0; k < NL; k++) begin
            conv_out_v[k] = (resp_cnt[k] == 1) | spur[k];
        end
    end

    // Pulse recorder: one entry per cycle per high pulse, plus a count of multi-hot cycles
    always @(negedge clk) begin
        int hot;
        hot = int'(lsb_clk) + $countones(conv_rst) + $countones(ac_clk) + int'(out_latch);
        if (hot > 1) multi_hot++;
        if (lsb_clk) trace.push_back(1);
        for (int k = 0; k < NL; k++) if (conv_rst[k]) trace.push_back(10 + k);
        for (int k = 0; k < NL - 1; k++) if (ac_clk[k]) trace.push_back(20 + k);
        if (out_latch) trace.push_back(30);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic raiseSample();
        @(posedge clk);
        #1 sample_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1 sample_clk = 1'b0;
    endtask

    task automatic applyStimulus(input int w0, input int w1, input int w2);
        wait_cfg[0] = w0;
        wait_cfg[1] = w1;
        wait_cfg[2] = w2;
        trace.delete();
        raiseSample();
    endtask

    task automatic waitPassDone(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_pass_ended"}, 32'(busy), 32'd0);
    endtask

    task automatic waitConvRst(input int k, input string tag);
        int n = 0;
        @(negedge clk);
        while (conv_rst[k] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(conv_rst[k]), 32'd1);
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    function automatic int countCode(input int code);
        int c = 0;
        foreach (trace[i]) if (trace[i] == code) c++;
        return c;
    endfunction

    task automatic checkOrder(input string tag);
        int expected_order [7] = '{1, 10, 20, 11, 21, 12, 30};
        checkOutput({tag, "_pulse_count"}, 32'(trace.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            int got;
            got = (i < trace.size()) ? trace[i] : -1;
            checkOutput($sformatf("%s_pulse%0d", tag, i), 32'(got), 32'(expected_order[i]));
        end
    endtask

    initial begin
        rst        = 1'b1;
        sample_clk = 1'b1;
        clear      = 1'b0;
        spur       = '0;
        for (int k = 0; k < NL; k++) wait_cfg[k] = 1;

        $display("[TB] reset values, sample_clk high across reset release");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pulses", 32'({lsb_clk, conv_rst, ac_clk, out_latch}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_flags", 32'({overrun, fault}), 32'd0);
        checkOutput("rst_last", last_pass_cycles, 32'd0);
        checkOutput("rst_max", max_pass_cycles, 32'd0);
        rst = 1'b0;
        trace.delete();
        repeat (12) @(negedge clk);
        checkOutput("high_at_release_no_pass", 32'(trace.size()), 32'd0);
        sample_clk = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] nominal pass");
        applyStimulus(1, 1, 1);
        waitPassDone("nominal");
        checkOrder("nominal");
        checkOutput("nominal_last", last_pass_cycles, 32'd10);
        checkOutput("nominal_max", max_pass_cycles, 32'd10);
        checkOutput("nominal_flags", 32'({overrun, fault}), 32'd0);

        $display("[TB] long waits then short pass");
        applyStimulus(5, 20, 7);
        waitPassDone("long");
        checkOrder("long");
        checkOutput("long_last", last_pass_cycles, 32'd39);
        checkOutput("long_max", max_pass_cycles, 32'd39);
        applyStimulus(1, 1, 1);
        waitPassDone("short");
        checkOutput("short_last", last_pass_cycles, 32'd10);
        checkOutput("short_max_kept", max_pass_cycles, 32'd39);

        pulseClear();
        checkOutput("clear_max", max_pass_cycles, 32'd0);
        checkOutput("clear_to_fault", 32'(to_fault), 32'd0);

        $display("[TB] timeout on layer 1");
        applyStimulus(1, 1000, 1);
        waitConvRst(1, "timeout_rst1_seen");
        repeat (16) @(negedge clk);
        checkOutput("to_fault_before_limit", 32'(to_fault), 32'd0);
        checkOutput("to_busy_before_limit", 32'(to_busy), 32'd1);
        @(negedge clk);
        checkOutput("to_fault_at_limit", 32'(to_fault), 32'd1);
        checkOutput("to_busy_at_limit", 32'(to_busy), 32'd0);
        checkOutput("main_fault_still_waiting", 32'(fault), 32'd0);
        waitPassDone("timeout");
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_no_ac1", 32'(countCode(21)), 32'd0);
        checkOutput("timeout_no_latch", 32'(countCode(30)), 32'd0);
        checkOutput("timeout_last_kept", last_pass_cycles, 32'd10);
        applyStimulus(2, 1, 1);
        waitPassDone("after_timeout");
        checkOrder("after_timeout");
        checkOutput("after_timeout_last", last_pass_cycles, 32'd11);
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        pulseClear();
        checkOutput("fault_cleared", 32'(fault), 32'd0);

        $display("[TB] overrun during WAIT_CONV(1)");
        applyStimulus(1, 20, 1);
        waitConvRst(1, "overrun_rst1_seen");
        raiseSample();
        waitPassDone("overrun");
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        checkOutput("overrun_one_latch", 32'(countCode(30)), 32'd1);
        checkOutput("overrun_last", last_pass_cycles, 32'd29);
        checkOutput("overrun_max", max_pass_cycles, 32'd29);
        repeat (10) @(negedge clk);
        checkOutput("overrun_not_queued", 32'(countCode(1)), 32'd1);
        checkOutput("overrun_idle", 32'(busy), 32'd0);
        pulseClear();
        checkOutput("overrun_cleared", 32'(overrun), 32'd0);

        $display("[TB] asynchronous reset during WAIT_CONV(2)");
        applyStimulus(1, 1, 20);
        waitConvRst(2, "reset_rst2_seen");
        repeat (3) @(negedge clk);
        checkOutput("reset_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_async_pulses", 32'({lsb_clk, conv_rst, ac_clk, out_latch}), 32'd0);
        checkOutput("reset_async_busy", 32'(busy), 32'd0);
        checkOutput("reset_async_last", last_pass_cycles, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < NL; k++) wait_cfg[k] = 1;
        repeat (4) @(posedge clk);
        trace.delete();
        @(posedge clk);
        #1 sample_clk = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("latency_lsb_not_yet", 32'(lsb_clk), 32'd0);
        @(negedge clk);
        checkOutput("latency_lsb_at_4", 32'(lsb_clk), 32'd1);
        repeat (2) @(posedge clk);
        #1 sample_clk = 1'b0;
        waitPassDone("after_reset");
        checkOutput("after_reset_last", last_pass_cycles, 32'd10);

        $display("[TB] spurious conv_out_v[2] during WAIT_CONV(0)");
        applyStimulus(3, 1, 1);
        waitConvRst(0, "spur_rst0_seen");
        spur = 3'b100;
        repeat (4) @(negedge clk);
        spur = 3'b000;
        waitPassDone("spurious");
        checkOrder("spurious");
        checkOutput("spurious_last", last_pass_cycles, 32'd12);

        checkOutput("one_hot_pulses", 32'(multi_hot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule
